ocp_master_arbiter: RTL

- Two-master, one-slave arbiter for the 8-bit OCP-lite command bus. Lets the UART master (m0) and a second master (m1, e.g. boot/script sequencer) share the single master port into the tree link.
- Round-robin grant per transaction, locked until the transaction completes.
- Registers the granted command onto the downstream port and routes the response back to the granted master only.

---
 rtl/ocp_master_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/ocp_master_arbiter.sv
// Two-master round-robin arbiter for the 8-bit OCP-lite command bus, locked per transaction.
// Define ARB_TIMEOUT_EN to add a read-response timeout of TIMEOUT_CYC cycles.
module ocp_master_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] m0_MCmd,
  input  logic [7:0] m0_MAddr,
  input  logic [7:0] m0_MData,
  output logic       m0_SCmdAccept,
  output logic [1:0] m0_SResp,
  output logic [7:0] m0_SData,
  input  logic [2:0] m1_MCmd,
  input  logic [7:0] m1_MAddr,
  input  logic [7:0] m1_MData,
  output logic       m1_SCmdAccept,
  output logic [1:0] m1_SResp,
  output logic [7:0] m1_SData,
  output logic [2:0] s_MCmd,
  output logic [7:0] s_MAddr,
  output logic [7:0] s_MData,
  input  logic       s_SCmdAccept,
  input  logic [1:0] s_SResp,
  input  logic [7:0] s_SData,
  output logic       arb_grant,
  output logic [1:0] arb_state
);

  localparam int unsigned CMD_W  = 3;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RESP_W = 2;

  localparam logic [CMD_W-1:0]  CMD_IDLE  = 3'b000;
  localparam logic [CMD_W-1:0]  CMD_WR    = 3'b001;
  localparam logic [CMD_W-1:0]  CMD_RD    = 3'b010;
  localparam logic [RESP_W-1:0] RESP_NONE = 2'b00;

  if ((TIMEOUT_CYC == 0) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout
    $error("ocp_master_arbiter: TIMEOUT_CYC must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMD  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              req0;
  logic              req1;
  logic              any_req;
  logic              pick;
  logic              timeout_hit;
  logic              resp_fire;
  logic [RESP_W-1:0] resp_val;
  logic [DATA_W-1:0] rdata_val;

  logic [CMD_W-1:0]  s_cmd_nxt;
  logic [ADDR_W-1:0] s_addr_nxt;
  logic [DATA_W-1:0] s_data_nxt;
  logic              grant_nxt;
  logic [RESP_W-1:0] m0_resp_nxt;
  logic [DATA_W-1:0] m0_rdata_nxt;
  logic [RESP_W-1:0] m1_resp_nxt;
  logic [DATA_W-1:0] m1_rdata_nxt;

  // Only write and read codes count as requests; everything else is ignored.
  assign req0    = (m0_MCmd == CMD_WR) || (m0_MCmd == CMD_RD);
  assign req1    = (m1_MCmd == CMD_WR) || (m1_MCmd == CMD_RD);
  assign any_req = req0 | req1;
  // On contention the master that was not granted last wins.
  assign pick    = (req0 & req1) ? ~arb_grant : req1;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned       CNT_W    = 8;
  localparam logic [RESP_W-1:0] RESP_ERR = 2'b11;

  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] to_cnt_inc;

  assign to_cnt_inc  = to_cnt + CNT_W'(1);
  assign timeout_hit = (state == ST_RESP) && (s_SResp == RESP_NONE) &&
                       (to_cnt_inc == CNT_W'(TIMEOUT_CYC));
  assign resp_val    = (s_SResp == RESP_NONE) ? RESP_ERR : s_SResp;
  assign rdata_val   = (s_SResp == RESP_NONE) ? '0 : s_SData;

  // Held at zero through CMD so every RESP visit starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == ST_RESP) begin
      to_cnt <= to_cnt_inc;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign resp_val    = s_SResp;
  assign rdata_val   = s_SData;
`endif

  assign resp_fire = (s_SResp != RESP_NONE) || timeout_hit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        if (s_SCmdAccept) begin
          state_nxt = (s_MCmd == CMD_RD) ? ST_RESP : ST_IDLE;
        end
      end
      ST_RESP: begin
        if (resp_fire) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs plus the combinational accepts.
  always_comb begin
    s_cmd_nxt     = s_MCmd;
    s_addr_nxt    = s_MAddr;
    s_data_nxt    = s_MData;
    grant_nxt     = arb_grant;
    m0_resp_nxt   = RESP_NONE;
    m0_rdata_nxt  = '0;
    m1_resp_nxt   = RESP_NONE;
    m1_rdata_nxt  = '0;
    m0_SCmdAccept = 1'b0;
    m1_SCmdAccept = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant_nxt  = pick;
          s_cmd_nxt  = pick ? m1_MCmd  : m0_MCmd;
          s_addr_nxt = pick ? m1_MAddr : m0_MAddr;
          s_data_nxt = pick ? m1_MData : m0_MData;
        end
      end
      ST_CMD: begin
        m0_SCmdAccept = ~arb_grant & s_SCmdAccept;
        m1_SCmdAccept = arb_grant & s_SCmdAccept;
        if (s_SCmdAccept) begin
          s_cmd_nxt = CMD_IDLE;
        end
      end
      ST_RESP: begin
        if (resp_fire) begin
          if (arb_grant) begin
            m1_resp_nxt  = resp_val;
            m1_rdata_nxt = rdata_val;
          end else begin
            m0_resp_nxt  = resp_val;
            m0_rdata_nxt = rdata_val;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered downstream command and upstream response pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_MCmd    <= CMD_IDLE;
      s_MAddr   <= '0;
      s_MData   <= '0;
      arb_grant <= 1'b1;
      m0_SResp  <= RESP_NONE;
      m0_SData  <= '0;
      m1_SResp  <= RESP_NONE;
      m1_SData  <= '0;
    end else begin
      s_MCmd    <= s_cmd_nxt;
      s_MAddr   <= s_addr_nxt;
      s_MData   <= s_data_nxt;
      arb_grant <= grant_nxt;
      m0_SResp  <= m0_resp_nxt;
      m0_SData  <= m0_rdata_nxt;
      m1_SResp  <= m1_resp_nxt;
      m1_SData  <= m1_rdata_nxt;
    end
  end

  assign arb_state = state;

endmodule
